// File: rtl/serial_addsub_pkg.sv
// Shared types and defaults for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_addsub_fadd.sv
// Single full-adder cell used as the bit-slice of the serial datapath.
module fadd (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full adder, LSB-first shift datapath.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_acc_next;

  fadd u_fadd (
    .a    (r_opa[0]),
    .b    (r_opb[0]),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};

  // FSM, operand load, per-bit shift and registered result/flag capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_opa    <= '0;
      r_opb    <= '0;
      r_acc    <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            // Subtract as a + ~b + 1: invert B and seed the carry with sub.
            r_opa   <= a;
            r_opb   <= b ^ {WIDTH{sub}};
            r_carry <= sub;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end else begin
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_acc   <= w_acc_next;
          r_opa   <= r_opa >> 1;
          r_opb   <= r_opb >> 1;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            // r_carry here is the carry into the MSB; xor with carry out gives signed overflow.
            result   <= w_acc_next;
            cout     <= w_cout;
            overflow <= r_carry ^ w_cout;
            busy     <= 1'b0;
            done     <= 1'b1;
            r_state  <= DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
